// File: rtl/fpu_pkg.sv
// Shared types and latency constants for the FPU issue scheduler and its
// write-back reservation table.
package fpu_pkg;

  localparam int LAT_ADD = 3;
  localparam int LAT_MUL = 2;
  localparam int LAT_CVT = 5;
  localparam int LAT_DIV = 12;
  localparam int MAX_LAT = 12;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_MUL = 2'd1,
    CLS_CVT = 2'd2,
    CLS_DIV = 2'd3
  } fpu_cls_e;

  typedef struct packed {
    logic     v;
    logic [4:0] rd;
    fpu_cls_e cls;
  } wb_slot_t;

  function automatic logic [CNT_W-1:0] lat_of(input fpu_cls_e c);
    case (c)
      CLS_ADD: return CNT_W'(LAT_ADD);
      CLS_MUL: return CNT_W'(LAT_MUL);
      CLS_CVT: return CNT_W'(LAT_CVT);
      default: return CNT_W'(LAT_DIV);
    endcase
  endfunction

endpackage

// File: rtl/fpu_wb_resv.sv
// Write-back reservation table. Position 0 is the registered write-back
// output; position k holds the result that reaches write-back k edges later.
module fpu_wb_resv
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             ins_en,
  input  logic [CNT_W-1:0] ins_lat,
  input  logic [4:0]       ins_rd,
  input  fpu_cls_e         ins_cls,
  input  logic [CNT_W-1:0] query_lat,
  output logic             query_free,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [1:0]       wb_sel
);

  wb_slot_t slot_q [MAX_LAT];
  wb_slot_t slot_d [MAX_LAT];

  // An op accepted now must land at position lat-1 after this edge's shift.
  always_comb begin
    for (int k = 0; k < MAX_LAT - 1; k++) slot_d[k] = slot_q[k + 1];
    slot_d[MAX_LAT - 1] = '0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (ins_en && (k + 1 == int'(ins_lat))) begin
        slot_d[k] = '{v: 1'b1, rd: ins_rd, cls: ins_cls};
      end
    end
    if (flush) begin
      for (int k = 0; k < MAX_LAT; k++) slot_d[k] = '0;
    end
  end

  // Pre-shift position lat moves to lat-1; position MAX_LAT is always empty.
  always_comb begin
    query_free = 1'b1;
    for (int k = 0; k < MAX_LAT; k++) begin
      if ((k == int'(query_lat)) && slot_q[k].v) query_free = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < MAX_LAT; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < MAX_LAT; k++) slot_q[k] <= slot_d[k];
    end
  end

  assign wb_valid = slot_q[0].v;
  assign wb_rd    = slot_q[0].rd;
  assign wb_sel   = slot_q[0].cls;

endmodule

// File: rtl/fpu_issue_sched.sv
// FPU issue scheduler: accepts one op per cycle, fires the unit, and
// reserves the single write-back slot so results never collide.
module fpu_issue_sched
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic [1:0] req_cls,
  input  logic [4:0] req_rd,
  output logic       req_ready,
  input  logic       flush,
  output logic [3:0] fire,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic [1:0] wb_sel,
  output logic       div_busy
);

  if (LAT_ADD > MAX_LAT || LAT_MUL > MAX_LAT || LAT_CVT > MAX_LAT ||
      LAT_DIV > MAX_LAT || LAT_ADD < 1 || LAT_MUL < 1 || LAT_CVT < 1 ||
      LAT_DIV < 1) begin : g_lat_check
    $error("fpu_issue_sched: a unit latency exceeds the reservation depth");
  end

  fpu_cls_e         cls;
  logic [CNT_W-1:0] req_lat;
  logic [CNT_W-1:0] div_cnt;
  logic             slot_free;
  logic             accept;

  assign cls       = fpu_cls_e'(req_cls);
  assign req_lat   = lat_of(cls);
  assign div_busy  = (div_cnt != '0);
  assign req_ready = rstn && !flush && slot_free && !(cls == CLS_DIV && div_busy);
  assign accept    = req_valid && req_ready;

  fpu_wb_resv u_resv (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .ins_en     (accept),
    .ins_lat    (req_lat),
    .ins_rd     (req_rd),
    .ins_cls    (cls),
    .query_lat  (req_lat),
    .query_free (slot_free),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_sel     (wb_sel)
  );

  // Loaded with LAT_DIV-1 so busy falls in the cycle the divide result retires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
    end else if (flush) begin
      div_cnt <= '0;
    end else if (accept && cls == CLS_DIV) begin
      div_cnt <= CNT_W'(LAT_DIV - 1);
    end else if (div_busy) begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fire <= '0;
    end else begin
      fire <= accept ? (4'b0001 << req_cls) : 4'b0000;
    end
  end

endmodule
